// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master is the loader side; slave is the byte source / memory side.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: unpacks a length/payload/checksum byte frame into 32-bit instruction-memory
// writes and keeps the core in reset until a verified image is present.
module imem_loader #(
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  imem_loader_if.master    bus,
  output logic             cpu_reset_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [AddrW:0]   word_count_o
);

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StData, StWrite, StCsum, StDone, StError
  } state_e;

  localparam logic [16:0] Capacity = 17'd1 << AddrW;

  state_e         state_q, state_d;
  logic [15:0]    len_q, len_d;
  logic [23:0]    word_q, word_d;
  logic [7:0]     csum_q, csum_d;
  logic [1:0]     idx_q, idx_d;
  logic [AddrW:0] wc_q, wc_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;

  logic        rx_ready;
  logic        accept;
  logic [15:0] len_n;

  always_comb begin
    rx_ready = (state_q == StLenHi) || (state_q == StLenLo) ||
               (state_q == StData)  || (state_q == StCsum);
  end

  assign accept = bus.rx_valid && rx_ready;
  assign len_n  = {len_q[15:8], bus.rx_data};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    wc_d    = wc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      StIdle, StDone, StError: begin
        if (start_i) begin
          wc_d    = '0;
          csum_d  = '0;
          idx_d   = '0;
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d   = {bus.rx_data, 8'h00};
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d = len_n;
          // Full 17-bit compare so lengths above capacity can never wrap.
          if ({1'b0, len_n} > Capacity) begin
            state_d = StError;
          end else if (len_n == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          word_d = {word_q[15:0], bus.rx_data};
          csum_d = csum_q ^ bus.rx_data;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            addr_d  = 32'({wc_q, 2'b00});
            wdata_d = {word_q, bus.rx_data};
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        wc_d = wc_q + 1'b1;
        if (16'(wc_q) + 16'd1 == len_q) begin
          state_d = StCsum;
        end else begin
          state_d = StData;
        end
      end
      StCsum: begin
        if (accept) begin
          state_d = (bus.rx_data == csum_q) ? StDone : StError;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      len_q   <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      idx_q   <= '0;
      wc_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
      wc_q    <= wc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.rx_ready   = rx_ready;
  assign bus.imem_we    = (state_q == StWrite);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy_o         = rx_ready || (state_q == StWrite);
  assign done_o         = (state_q == StDone);
  assign error_o        = (state_q == StError);
  assign cpu_reset_o    = (state_q != StDone);
  assign word_count_o   = wc_q;

endmodule
